// File: rtl/player_motion_ctrl.sv
// Player movement sequencer: on each update tick, builds a clamped candidate position from the
// direction buttons, validates it with an external collision checker, wall-slides, then commits.
module player_motion_ctrl #(
    parameter int POS_W       = 10,
    parameter int STEP        = 1,
    parameter int CLK_HZ      = 50_000_000,
    parameter int UPDATE_HZ   = 100,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 620,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 460,
    parameter int X_INIT      = 310,
    parameter int Y_INIT      = 230,
    parameter int CHK_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             flip_vert,
    output logic             chk_req,
    output logic [POS_W-1:0] chk_x,
    output logic [POS_W-1:0] chk_y,
    input  logic             chk_done,
    input  logic             chk_ok,
    output logic [POS_W-1:0] x_pos,
    output logic [POS_W-1:0] y_pos,
    output logic             moved,
    output logic             busy,
    output logic             chk_err
);

    localparam int PERIOD = CLK_HZ / UPDATE_HZ;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TO_W   = (CHK_TIMEOUT > 1) ? $clog2(CHK_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(CHK_TIMEOUT - 1);
    localparam logic [POS_W:0]   STEP_W   = (POS_W + 1)'(STEP);
    localparam logic [POS_W:0]   X_LO     = (POS_W + 1)'(X_MIN);
    localparam logic [POS_W:0]   X_HI     = (POS_W + 1)'(X_MAX);
    localparam logic [POS_W:0]   Y_LO     = (POS_W + 1)'(Y_MIN);
    localparam logic [POS_W:0]   Y_HI     = (POS_W + 1)'(Y_MAX);
    localparam logic [POS_W-1:0] X_RST    = POS_W'(X_INIT);
    localparam logic [POS_W-1:0] Y_RST    = POS_W'(Y_INIT);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SAMPLE,
        S_REQ_XY,
        S_WAIT_XY,
        S_REQ_X,
        S_WAIT_X,
        S_REQ_Y,
        S_WAIT_Y,
        S_REQ_1,
        S_WAIT_1,
        S_COMMIT
    } state_t;

    state_t state, state_n;

    logic [CNT_W-1:0] tick_cnt;
    logic [TO_W-1:0]  wait_cnt;
    logic             tick;
    logic             pending;
    logic             lat_left, lat_right, lat_up, lat_down;
    logic [POS_W-1:0] cand_x, cand_y;
    logic [POS_W-1:0] new_x, new_y;
    logic [POS_W-1:0] cx_c, cy_c;
    logic             move_x, move_y;
    logic             waiting, timed_out, resolve, accept;

    // One signed step widened by a bit, so a move below zero is caught as a borrow, not a wrap.
    function automatic logic [POS_W-1:0] step_clamp(
        input logic [POS_W-1:0] cur,
        input logic             dec,
        input logic             inc,
        input logic [POS_W:0]   lo,
        input logic [POS_W:0]   hi
    );
        logic [POS_W:0] sum;
        sum = {1'b0, cur};
        if (inc && !dec) begin
            sum = sum + STEP_W;
        end else if (dec && !inc) begin
            sum = sum - STEP_W;
            if (sum[POS_W]) sum = lo;
        end
        if (sum < lo)      sum = lo;
        else if (sum > hi) sum = hi;
        return sum[POS_W-1:0];
    endfunction

    assign tick      = enable && (tick_cnt == CNT_LAST);
    assign cx_c      = step_clamp(x_pos, lat_left, lat_right, X_LO, X_HI);
    assign cy_c      = step_clamp(y_pos, lat_up, lat_down, Y_LO, Y_HI);
    assign move_x    = (cx_c != x_pos);
    assign move_y    = (cy_c != y_pos);
    assign waiting   = (state == S_WAIT_XY) || (state == S_WAIT_X) ||
                       (state == S_WAIT_Y)  || (state == S_WAIT_1);
    assign timed_out = waiting && !chk_done && (wait_cnt == TO_LAST);
    assign resolve   = waiting && (chk_done || timed_out);
    assign accept    = waiting && chk_done && chk_ok;
    assign busy      = (state != S_IDLE);

    // enable only gates the tick source; a tick already pending is still served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  tick_cnt <= '0;
        else if (!enable || tick) tick_cnt <= '0;
        else                      tick_cnt <= tick_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // NOTE: state_n gets its default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (tick || pending) state_n = S_SAMPLE;
            S_SAMPLE: begin
                if (move_x && move_y)      state_n = S_REQ_XY;
                else if (move_x || move_y) state_n = S_REQ_1;
                else                       state_n = S_IDLE;
            end
            S_REQ_XY:  state_n = S_WAIT_XY;
            S_REQ_X:   state_n = S_WAIT_X;
            S_REQ_Y:   state_n = S_WAIT_Y;
            S_REQ_1:   state_n = S_WAIT_1;
            S_WAIT_XY: begin
                if (accept)       state_n = S_COMMIT;
                else if (resolve) state_n = S_REQ_X;
            end
            S_WAIT_X:  if (resolve) state_n = S_REQ_Y;
            S_WAIT_Y:  if (resolve) state_n = S_COMMIT;
            S_WAIT_1: begin
                if (accept)       state_n = S_COMMIT;
                else if (resolve) state_n = S_IDLE;
            end
            S_COMMIT:  state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= 1'b0;
            lat_left  <= 1'b0;
            lat_right <= 1'b0;
            lat_up    <= 1'b0;
            lat_down  <= 1'b0;
            cand_x    <= X_RST;
            cand_y    <= Y_RST;
            new_x     <= X_RST;
            new_y     <= Y_RST;
            chk_req   <= 1'b0;
            chk_x     <= X_RST;
            chk_y     <= Y_RST;
            wait_cnt  <= '0;
            x_pos     <= X_RST;
            y_pos     <= Y_RST;
            moved     <= 1'b0;
            chk_err   <= 1'b0;
        end else begin
            moved <= 1'b0;

            if (tick && state != S_IDLE) pending <= 1'b1;
            else if (state == S_IDLE)    pending <= 1'b0;

            case (state)
                S_IDLE: begin
                    lat_left  <= btn_left;
                    lat_right <= btn_right;
                    lat_up    <= flip_vert ? btn_down : btn_up;
                    lat_down  <= flip_vert ? btn_up : btn_down;
                end
                S_SAMPLE: begin
                    cand_x <= cx_c;
                    cand_y <= cy_c;
                    new_x  <= x_pos;
                    new_y  <= y_pos;
                end
                S_REQ_XY, S_REQ_1: begin
                    chk_x    <= cand_x;
                    chk_y    <= cand_y;
                    chk_req  <= 1'b1;
                    wait_cnt <= '0;
                end
                S_REQ_X: begin
                    chk_x    <= cand_x;
                    chk_y    <= y_pos;
                    chk_req  <= 1'b1;
                    wait_cnt <= '0;
                end
                S_REQ_Y: begin
                    chk_x    <= new_x;
                    chk_y    <= cand_y;
                    chk_req  <= 1'b1;
                    wait_cnt <= '0;
                end
                S_COMMIT: begin
                    x_pos <= new_x;
                    y_pos <= new_y;
                    moved <= (new_x != x_pos) || (new_y != y_pos);
                end
                default: ;
            endcase

            // Non-moving axis already holds its current value, so WAIT_1 can accept both.
            if (waiting) begin
                if (resolve) begin
                    chk_req  <= 1'b0;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + TO_W'(1);
                end
                if (timed_out) chk_err <= 1'b1;
                if (accept) begin
                    if (state != S_WAIT_Y) new_x <= cand_x;
                    if (state != S_WAIT_X) new_y <= cand_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Randomized bench for player_motion_ctrl: a behavioural update model predicts the handshakes
// and committed position of each update; a checker model answers requests from a wall map.
module tb_player_motion_ctrl;

    localparam int POS_W   = 10;
    localparam int PERIOD  = 10;
    localparam int STEP    = 1;
    localparam int X_MIN   = 0;
    localparam int X_MAX   = 620;
    localparam int Y_MIN   = 0;
    localparam int Y_MAX   = 460;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic             flip_vert = 1'b0;
    logic             chk_req;
    logic [POS_W-1:0] chk_x, chk_y;
    logic             chk_done, chk_ok;
    logic [POS_W-1:0] x_pos, y_pos;
    logic             moved, busy, chk_err;

    int n_tests = 0;
    int n_fail  = 0;
    int wall_mode = 0;
    bit mute = 1'b0;
    int m_x = 310, m_y = 230;
    int exp_n, exp_nx, exp_ny;
    int exp_x[3], exp_y[3];
    int hs_x[$], hs_y[$];

    player_motion_ctrl #(
        .POS_W(POS_W), .STEP(STEP), .CLK_HZ(1000), .UPDATE_HZ(100),
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
        .X_INIT(310), .Y_INIT(230), .CHK_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .flip_vert(flip_vert),
        .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y),
        .chk_done(chk_done), .chk_ok(chk_ok),
        .x_pos(x_pos), .y_pos(y_pos),
        .moved(moved), .busy(busy), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Wall map seen by the checker model.
    function automatic bit wall_ok(input int x, input int y);
        case (wall_mode)
            0:       return 1'b1;
            1:       return y <= 230;
            2:       return ((x * 7 + y * 3) % 5) != 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    // One update from the current buttons: expected handshake list and final position.
    function automatic void model_update();
        int dx, dy, cx, cy;
        bit neg_y, pos_y;
        neg_y = flip_vert ? btn_down : btn_up;
        pos_y = flip_vert ? btn_up : btn_down;
        dx = (btn_right && !btn_left) ? 1 : (btn_left && !btn_right) ? -1 : 0;
        dy = (pos_y && !neg_y) ? 1 : (neg_y && !pos_y) ? -1 : 0;
        cx = clampi(m_x + dx * STEP, X_MIN, X_MAX);
        cy = clampi(m_y + dy * STEP, Y_MIN, Y_MAX);
        exp_n = 0; exp_nx = m_x; exp_ny = m_y;
        if (cx != m_x && cy != m_y) begin
            exp_x[0] = cx; exp_y[0] = cy; exp_n = 1;
            if (wall_ok(cx, cy)) begin
                exp_nx = cx; exp_ny = cy;
            end else begin
                exp_x[1] = cx; exp_y[1] = m_y; exp_n = 2;
                if (wall_ok(cx, m_y)) exp_nx = cx;
                exp_x[2] = exp_nx; exp_y[2] = cy; exp_n = 3;
                if (wall_ok(exp_nx, cy)) exp_ny = cy;
            end
        end else if (cx != m_x || cy != m_y) begin
            exp_x[0] = cx; exp_y[0] = cy; exp_n = 1;
            if (wall_ok(cx, cy)) begin
                exp_nx = cx; exp_ny = cy;
            end
        end
    endfunction

    // Checker model: logs every new request, answers on its second cycle unless muted.
    initial begin
        int age;
        age = 0;
        chk_done = 1'b0;
        chk_ok   = 1'b0;
        forever begin
            @(negedge clk);
            chk_done = 1'b0;
            chk_ok   = 1'b0;
            if (!chk_req) begin
                age = 0;
            end else begin
                age++;
                if (age == 1) begin
                    hs_x.push_back(int'(chk_x));
                    hs_y.push_back(int'(chk_y));
                end
                if (age == 2 && !mute) begin
                    chk_done = 1'b1;
                    chk_ok   = wall_ok(int'(chk_x), int'(chk_y));
                end
            end
        end
    end

    // Called at a negedge with busy low; runs one full update and compares it with the model.
    task automatic run_update(input string tag);
        int n;
        model_update();
        hs_x.delete();
        hs_y.delete();
        n = 0;
        while (!busy && n < 4 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s start", tag), busy, 1);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s end", tag), busy, 0);
        check($sformatf("%s handshakes", tag), hs_x.size(), exp_n);
        for (int i = 0; i < exp_n && i < hs_x.size(); i++) begin
            check($sformatf("%s hs%0d chk_x", tag, i), hs_x[i], exp_x[i]);
            check($sformatf("%s hs%0d chk_y", tag, i), hs_y[i], exp_y[i]);
        end
        check($sformatf("%s x_pos", tag), x_pos, exp_nx);
        check($sformatf("%s y_pos", tag), y_pos, exp_ny);
        check($sformatf("%s moved", tag), moved, (exp_nx != m_x) || (exp_ny != m_y));
        m_x = exp_nx;
        m_y = exp_ny;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int n, lat, rises;
        logic prev;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset x_pos", x_pos, 310);
        check("reset y_pos", y_pos, 230);
        check("reset chk_x", chk_x, 310);
        check("reset chk_y", chk_y, 230);
        check("reset chk_req", chk_req, 0);
        check("reset moved", moved, 0);
        check("reset busy", busy, 0);
        check("reset chk_err", chk_err, 0);
        enable = 1'b1;

        // Reset in the middle of a diagonal handshake.
        mute = 1'b1;
        btn_right = 1'b1;
        btn_down  = 1'b1;
        n = 0;
        while (!chk_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t1 req raised", chk_req, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t1 chk_req drop", chk_req, 0);
        check("t1 busy", busy, 0);
        check("t1 x_pos", x_pos, 310);
        check("t1 y_pos", y_pos, 230);
        check("t1 chk_err", chk_err, 0);
        @(negedge clk);
        rst  = 1'b0;
        mute = 1'b0;
        m_x  = 310;
        m_y  = 230;

        // Diagonal blocked, x slide accepted, y slide blocked.
        wall_mode = 1;
        run_update("t3 slide");
        check("t3 x_pos", x_pos, 311);
        check("t3 y_pos", y_pos, 230);

        // Free movement right, one update per tick.
        wall_mode = 0;
        btn_down  = 1'b0;
        for (int i = 0; i < 5; i++) run_update($sformatf("t2 step%0d", i));

        // Walk to the right edge, then push against it.
        for (int i = 0; i < 400 && m_x < X_MAX; i++) run_update("t4 walk");
        run_update("t4 at max");
        check("t4 x at max", x_pos, X_MAX);

        // Flipped vertical sense, then opposing buttons.
        btn_right = 1'b0;
        btn_up    = 1'b1;
        flip_vert = 1'b1;
        run_update("t5 flip");
        check("t5 y_pos", y_pos, 231);
        btn_up    = 1'b0;
        flip_vert = 1'b0;
        btn_left  = 1'b1;
        btn_right = 1'b1;
        run_update("t5 cancel");

        // Random buttons against a scattered wall map.
        wall_mode = 2;
        for (int t = 0; t < 80; t++) begin
            {btn_left, btn_right, btn_up, btn_down, flip_vert} = 5'($urandom);
            run_update($sformatf("rnd%0d", t));
        end

        // Checker never answers: every wait times out, position holds, one tick stays pending.
        wall_mode = 3;
        mute      = 1'b1;
        {btn_left, btn_right, btn_up, btn_down, flip_vert} = 5'b10100;
        model_update();
        hs_x.delete();
        hs_y.delete();
        n = 0;
        while (!chk_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6 req raised", chk_req, 1);
        lat = 0;
        while (!chk_err && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("t6 timeout cycles", lat, 8);
        n = 0;
        while (hs_x.size() < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        enable = 1'b0;
        {btn_left, btn_right, btn_up, btn_down, flip_vert} = 5'b00000;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6 end", busy, 0);
        check("t6 handshakes", hs_x.size(), exp_n);
        check("t6 x_pos", x_pos, m_x);
        check("t6 y_pos", y_pos, m_y);
        check("t6 moved", moved, 0);
        rises = 0;
        prev  = busy;
        repeat (40) begin
            @(negedge clk);
            if (busy && !prev) rises++;
            prev = busy;
        end
        check("t6 pending updates", rises, 1);
        check("t6 chk_err sticky", chk_err, 1);
        check("t6 x_pos after", x_pos, m_x);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
